line_follow_ctrl: RTL and testbench

//  Parametrised line-follower controller for N reflective sensors.

---
 rtl/line_follow_ctrl.sv | 263 ++++++++++++++++++++++++++
 tb/tb_line_follow_ctrl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/line_follow_ctrl.sv
// line_follow_ctrl: line-follower controller for N_SENS reflective sensors.
// A registered sensor sample drives a weighted steering error and a
// TRACK/SEARCH/STOP/FAULT state machine. The state machine sets per-motor
// speed/direction targets, and the speed outputs approach those targets in
// slew-limited steps. A motor only changes direction while stopped.
// Ports:
//   clk            system clock
//   rst_n          async active-low reset (zeroes speeds immediately)
//   enable         run request; low forces IDLE on the next cycle
//   sensors        filtered sensor levels, bit N_SENS-1 = leftmost
//   spd_l, spd_r   motor speeds to the PWM instances
//   dir_l, dir_r   motor directions (1 = forward)
//   state          IDLE=0 TRACK=1 SEARCH=2 STOP=3 FAULT=4
module line_follow_ctrl #(
  parameter int N_SENS       = 5,
  parameter int SPD_W        = 8,
  parameter int LINE_LVL     = 0,
  parameter int MAX_SPD      = 15,
  parameter int KP           = 3,
  parameter int SEARCH_SPD   = 6,
  parameter int RAMP_STEP    = 1,
  parameter int RAMP_DIV     = 1,
  parameter int LOST_TIMEOUT = 1000,
  parameter int END_CYCLES   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [N_SENS-1:0] sensors,
  output logic [SPD_W-1:0]  spd_l,
  output logic [SPD_W-1:0]  spd_r,
  output logic              dir_l,
  output logic              dir_r,
  output logic [2:0]        state
);

  localparam int C       = (N_SENS - 1) / 2;
  localparam int ERR_W   = $clog2(C * (C + 1) / 2 + 1) + 1;
  localparam int SPD_TOP = (1 << SPD_W) - 1;
  localparam int END_W   = $clog2(END_CYCLES + 1);
  localparam int LOST_W  = $clog2(LOST_TIMEOUT + 1);
  localparam int DIV_W   = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_TRACK  = 3'd1,
    ST_SEARCH = 3'd2,
    ST_STOP   = 3'd3,
    ST_FAULT  = 3'd4
  } state_t;

  // Clamp an arithmetic speed result into the unsigned speed range.
  function automatic logic [SPD_W-1:0] sat_spd(input int v);
    if (v < 0) begin
      sat_spd = {SPD_W{1'b0}};
    end else if (v > SPD_TOP) begin
      sat_spd = SPD_W'(SPD_TOP);
    end else begin
      sat_spd = SPD_W'(v);
    end
  endfunction

  localparam logic [SPD_W-1:0] ZERO_SPD   = {SPD_W{1'b0}};
  localparam logic [SPD_W-1:0] STEP_V     = SPD_W'(RAMP_STEP);
  localparam logic [SPD_W-1:0] CRUISE_V   = SPD_W'(MAX_SPD);
  localparam logic [SPD_W-1:0] SEARCH_V   = SPD_W'(SEARCH_SPD);

  // One slew step from cur toward tgt; lands exactly when within one step.
  function automatic logic [SPD_W-1:0] ramp_toward(input logic [SPD_W-1:0] cur,
                                                   input logic [SPD_W-1:0] tgt);
    if (tgt >= cur) begin
      if ((tgt - cur) <= STEP_V) ramp_toward = tgt;
      else                       ramp_toward = cur + STEP_V;
    end else begin
      if ((cur - tgt) <= STEP_V) ramp_toward = tgt;
      else                       ramp_toward = cur - STEP_V;
    end
  endfunction

  // Motor update on a tick, returned as {dir, spd}. A direction mismatch
  // first brings the motor to zero, then flips dir on a tick at zero.
  function automatic logic [SPD_W:0] motor_step(input logic dir, input logic tgt_dir,
                                                input logic [SPD_W-1:0] spd,
                                                input logic [SPD_W-1:0] tgt);
    if (tgt_dir != dir) begin
      if (spd == ZERO_SPD) motor_step = {tgt_dir, spd};
      else                 motor_step = {dir, ramp_toward(spd, ZERO_SPD)};
    end else begin
      motor_step = {dir, ramp_toward(spd, tgt)};
    end
  endfunction

  logic [N_SENS-1:0]       sens_q;
  logic [N_SENS-1:0]       on_s;
  logic                    any_on_s, all_on_s;
  logic signed [ERR_W-1:0] err_s;
  int                      err_mag_s;
  logic [SPD_W-1:0]        inner_s;
  state_t                  state_q;
  logic [SPD_W-1:0]        tgt_l_q, tgt_r_q;
  logic                    tgt_dir_l_q, tgt_dir_r_q;
  logic                    last_left_q;
  logic [END_W-1:0]        end_cnt_q;
  logic [LOST_W-1:0]       lost_cnt_q;
  logic [DIV_W-1:0]        div_q;
  logic                    ramp_tick_s;
  logic [SPD_W-1:0]        spd_l_q, spd_r_q, spd_l_d, spd_r_d;
  logic                    dir_l_q, dir_r_q, dir_l_d, dir_r_d;

  assign on_s     = (LINE_LVL != 0) ? sens_q : ~sens_q;
  assign any_on_s = |on_s;
  assign all_on_s = &on_s;

  // Weighted steering error: sensor i contributes (i - C) when over the line.
  always_comb begin
    err_s = {ERR_W{1'b0}};
    for (int i = 0; i < N_SENS; i++) begin
      if (on_s[i]) err_s = err_s + ERR_W'(i - C);
      else         err_s = err_s;
    end
  end

  // Slowed inner-wheel target for the current error magnitude.
  always_comb begin
    err_mag_s = int'(err_s);
    if (err_mag_s < 0) err_mag_s = -err_mag_s;
    else               err_mag_s = err_mag_s;
    inner_s = sat_spd(MAX_SPD - KP * err_mag_s);
  end

  // Sensor sample register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sens_q <= {N_SENS{1'b0}};
    else        sens_q <= sensors;
  end

  // State machine, motion targets, last-seen side and the end/lost counters.
  // Targets follow the current state; a lost line in TRACK holds them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      tgt_l_q     <= ZERO_SPD;
      tgt_r_q     <= ZERO_SPD;
      tgt_dir_l_q <= 1'b1;
      tgt_dir_r_q <= 1'b1;
      last_left_q <= 1'b1;
      end_cnt_q   <= {END_W{1'b0}};
      lost_cnt_q  <= {LOST_W{1'b0}};
    end else begin
      case (state_q)
        ST_TRACK: begin
          if (any_on_s) begin
            tgt_dir_l_q <= 1'b1;
            tgt_dir_r_q <= 1'b1;
            if (err_s > 0) begin
              tgt_l_q <= inner_s;
              tgt_r_q <= CRUISE_V;
            end else if (err_s < 0) begin
              tgt_l_q <= CRUISE_V;
              tgt_r_q <= inner_s;
            end else begin
              tgt_l_q <= CRUISE_V;
              tgt_r_q <= CRUISE_V;
            end
            if (err_s != 0) last_left_q <= (err_s > 0);
          end
        end
        ST_SEARCH: begin
          tgt_l_q     <= SEARCH_V;
          tgt_r_q     <= SEARCH_V;
          tgt_dir_l_q <= ~last_left_q;
          tgt_dir_r_q <= last_left_q;
        end
        default: begin
          tgt_l_q <= ZERO_SPD;
          tgt_r_q <= ZERO_SPD;
        end
      endcase

      if (!enable) begin
        state_q    <= ST_IDLE;
        end_cnt_q  <= {END_W{1'b0}};
        lost_cnt_q <= {LOST_W{1'b0}};
      end else begin
        case (state_q)
          ST_IDLE: state_q <= ST_TRACK;
          ST_TRACK: begin
            lost_cnt_q <= {LOST_W{1'b0}};
            if (!any_on_s) begin
              state_q   <= ST_SEARCH;
              end_cnt_q <= {END_W{1'b0}};
            end else if (all_on_s) begin
              if (end_cnt_q == END_W'(END_CYCLES - 1)) begin
                state_q   <= ST_STOP;
                end_cnt_q <= {END_W{1'b0}};
              end else begin
                end_cnt_q <= end_cnt_q + END_W'(1);
              end
            end else begin
              end_cnt_q <= {END_W{1'b0}};
            end
          end
          ST_SEARCH: begin
            if (any_on_s) begin
              state_q    <= ST_TRACK;
              lost_cnt_q <= {LOST_W{1'b0}};
            end else if (lost_cnt_q == LOST_W'(LOST_TIMEOUT - 1)) begin
              state_q    <= ST_FAULT;
              lost_cnt_q <= {LOST_W{1'b0}};
            end else begin
              lost_cnt_q <= lost_cnt_q + LOST_W'(1);
            end
          end
          ST_STOP:  state_q <= ST_STOP;
          ST_FAULT: state_q <= ST_FAULT;
          default:  state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign ramp_tick_s = (div_q == DIV_W'(RAMP_DIV - 1));

  // Free-running ramp divider.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           div_q <= {DIV_W{1'b0}};
    else if (ramp_tick_s) div_q <= {DIV_W{1'b0}};
    else                  div_q <= div_q + DIV_W'(1);
  end

  // Next speed/direction of both motors.
  always_comb begin
    if (ramp_tick_s) begin
      {dir_l_d, spd_l_d} = motor_step(dir_l_q, tgt_dir_l_q, spd_l_q, tgt_l_q);
      {dir_r_d, spd_r_d} = motor_step(dir_r_q, tgt_dir_r_q, spd_r_q, tgt_r_q);
    end else begin
      {dir_l_d, spd_l_d} = {dir_l_q, spd_l_q};
      {dir_r_d, spd_r_d} = {dir_r_q, spd_r_q};
    end
  end

  // Speed and direction output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spd_l_q <= ZERO_SPD;
      spd_r_q <= ZERO_SPD;
      dir_l_q <= 1'b1;
      dir_r_q <= 1'b1;
    end else begin
      spd_l_q <= spd_l_d;
      spd_r_q <= spd_r_d;
      dir_l_q <= dir_l_d;
      dir_r_q <= dir_r_d;
    end
  end

  assign spd_l = spd_l_q;
  assign spd_r = spd_r_q;
  assign dir_l = dir_l_q;
  assign dir_r = dir_r_q;
  assign state = state_q;

endmodule

// File: tb/tb_line_follow_ctrl.sv
// Directed bench for line_follow_ctrl with default parameters. Expected
// output tuples are queued with the clock count at which they fall due and
// are checked as the clock reaches that count.
module tb_line_follow_ctrl;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic [4:0] sensors;
  logic [7:0] spd_l, spd_r;
  logic       dir_l, dir_r;
  logic [2:0] state;

  line_follow_ctrl dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .enable  (enable),
    .sensors (sensors),
    .spd_l   (spd_l),
    .spd_r   (spd_r),
    .dir_l   (dir_l),
    .dir_r   (dir_r),
    .state   (state)
  );

  localparam int IDLE = 0, TRACK = 1, SEARCH = 2, STOP = 3, FAULT = 4;

  typedef struct {
    string tag;
    int    due;
    int    sl;
    int    sr;
    int    dl;
    int    dr;
    int    st;
  } exp_t;

  exp_t sb[$];
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input string tag, input int off, input int sl, input int sr,
                         input int dl, input int dr, input int st);
    exp_t e;
    e.tag = tag; e.due = cyc + off;
    e.sl = sl; e.sr = sr; e.dl = dl; e.dr = dr; e.st = st;
    sb.push_back(e);
  endtask

  task automatic check_now();
    exp_t e;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      cmp({e.tag, ".spd_l"}, int'(spd_l), e.sl);
      cmp({e.tag, ".spd_r"}, int'(spd_r), e.sr);
      cmp({e.tag, ".dir_l"}, int'(dir_l), e.dl);
      cmp({e.tag, ".dir_r"}, int'(dir_r), e.dr);
      cmp({e.tag, ".state"}, int'(state), e.st);
    end
  endtask

  task automatic adv(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      cyc++;
      check_now();
    end
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; sensors = 5'b11111;
    #12;
    sb_push("reset", 0, 0, 0, 1, 1, IDLE);
    check_now();
    rst_n = 1'b1;
    adv(1);

    // Centred line: ramp both motors from 0 to cruise.
    enable = 1'b1; sensors = 5'b11011;
    sb_push("t1_enter",  1,  0,  0, 1, 1, TRACK);
    sb_push("t1_first",  3,  1,  1, 1, 1, TRACK);
    sb_push("t1_mid",   10,  8,  8, 1, 1, TRACK);
    sb_push("t1_top",   17, 15, 15, 1, 1, TRACK);
    sb_push("t1_hold",  20, 15, 15, 1, 1, TRACK);
    adv(20);

    // err=+3: left target 15-9=6, nine ticks down.
    sensors = 5'b00111;
    sb_push("t2_lat",    1, 15, 15, 1, 1, TRACK);
    sb_push("t2_first",  3, 14, 15, 1, 1, TRACK);
    sb_push("t2_mid",   10,  7, 15, 1, 1, TRACK);
    sb_push("t2_end",   11,  6, 15, 1, 1, TRACK);
    sb_push("t2_hold",  13,  6, 15, 1, 1, TRACK);
    adv(13);

    // Line lost: pivot left, left motor reverses through zero.
    sensors = 5'b11111;
    sb_push("t3_lat",    1,  6, 15, 1, 1, TRACK);
    sb_push("t3_enter",  2,  6, 15, 1, 1, SEARCH);
    sb_push("t3_first",  4,  5, 14, 1, 1, SEARCH);
    sb_push("t3_zero",   9,  0,  9, 1, 1, SEARCH);
    sb_push("t3_flip",  10,  0,  8, 0, 1, SEARCH);
    sb_push("t3_up",    12,  2,  6, 0, 1, SEARCH);
    sb_push("t3_pivot", 16,  6,  6, 0, 1, SEARCH);
    adv(16);

    // SEARCH entered 14 cycles ago: FAULT after 1000 SEARCH cycles.
    sb_push("t4_last",  985, 6, 6, 0, 1, SEARCH);
    sb_push("t4_fault", 986, 6, 6, 0, 1, FAULT);
    sb_push("t4_down",  988, 5, 5, 0, 1, FAULT);
    sb_push("t4_zero",  993, 0, 0, 0, 1, FAULT);
    sb_push("t4_stick", 1000, 0, 0, 0, 1, FAULT);
    adv(1000);
    enable = 1'b0;
    sb_push("t4_idle",  1, 0, 0, 0, 1, IDLE);
    sb_push("t4_idle2", 3, 0, 0, 0, 1, IDLE);
    adv(3);

    // Back to TRACK: left flips forward at zero, then ramps.
    enable = 1'b1; sensors = 5'b11011;
    sb_push("t5_enter",  1,  0,  0, 0, 1, TRACK);
    sb_push("t5_flip",   3,  0,  1, 1, 1, TRACK);
    sb_push("t5_top",   18, 15, 15, 1, 1, TRACK);
    sb_push("t5_hold",  20, 15, 15, 1, 1, TRACK);
    adv(20);
    // Three all-on samples: no STOP.
    sensors = 5'b00000;
    sb_push("t5_three", 3, 15, 15, 1, 1, TRACK);
    adv(3);
    sensors = 5'b11011;
    sb_push("t5_nostop", 3, 15, 15, 1, 1, TRACK);
    adv(3);
    // Four all-on samples: STOP, then ramp down.
    sensors = 5'b00000;
    sb_push("t5_pre",   4, 15, 15, 1, 1, TRACK);
    sb_push("t5_stop",  5, 15, 15, 1, 1, STOP);
    sb_push("t5_down",  7, 14, 14, 1, 1, STOP);
    sb_push("t5_zero", 21,  0,  0, 1, 1, STOP);
    sb_push("t5_stick", 25, 0,  0, 1, 1, STOP);
    adv(25);

    // Asynchronous reset mid-ramp while reversing.
    enable = 1'b0; sensors = 5'b11111;
    sb_push("t6_idle", 1, 0, 0, 1, 1, IDLE);
    adv(1);
    enable = 1'b1;
    sb_push("t6_track",  1, 0, 0, 1, 1, TRACK);
    sb_push("t6_search", 2, 0, 0, 1, 1, SEARCH);
    sb_push("t6_flip",   4, 0, 1, 0, 1, SEARCH);
    sb_push("t6_mid",    7, 3, 4, 0, 1, SEARCH);
    adv(7);
    #3;
    rst_n = 1'b0;
    #1;
    sb_push("t6_async", 0, 0, 0, 1, 1, IDLE);
    check_now();

    cmp("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
